// File: rtl/seqdet_stream_ctrl.sv
// ============================================================================
// Module  : seqdet_stream_ctrl
// Brief   : Serializes a valid/ready word stream MSB-first into a programmable
//           pattern matcher with a saturating match counter and threshold irq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seqdet_stream_ctrl #(
  parameter int WORD_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_err,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               irq,
  input  logic               irq_clr
);

  localparam int c_BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int c_FILL_W = $clog2(PAT_MAX + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  logic [WORD_W-1:0]    r_word;
  logic [c_BIT_W-1:0]   r_bitcnt;
  logic [PAT_MAX-1:0]   r_hist;
  logic [c_FILL_W-1:0]  r_fill;
  logic [PAT_MAX-1:0]   r_pattern;
  logic [3:0]           r_len;
  logic [CNT_W-1:0]     r_thresh;
  logic                 r_match;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_irq;
  logic                 r_cfg_err;

  logic                 w_last;
  logic                 w_ready;
  logic                 w_accept;
  logic [PAT_MAX-1:0]   w_hist_next;
  logic [c_FILL_W-1:0]  w_fill_next;
  logic [c_FILL_W-1:0]  w_len_eff;
  logic [PAT_MAX-1:0]   w_mask;
  logic                 w_hit;
  logic                 w_cfg_ok;
  logic                 w_cnt_inc;
  logic                 w_irq_set;

  // The last SHIFT cycle also offers ready so consecutive words run without a bubble.
  assign w_last   = (r_bitcnt == '0);
  assign w_ready  = !rst && ((r_state == ST_IDLE) || w_last);
  assign w_accept = s_valid && w_ready;

  assign w_hist_next = {r_hist[PAT_MAX-2:0], r_word[WORD_W-1]};
  assign w_fill_next = (r_fill == c_FILL_W'(PAT_MAX)) ? r_fill : r_fill + c_FILL_W'(1);

  always_comb begin
    w_len_eff = (int'(r_len) > PAT_MAX) ? c_FILL_W'(PAT_MAX) : c_FILL_W'(r_len);
    w_mask    = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (i < int'(w_len_eff)) w_mask[i] = 1'b1;
    end
  end

  assign w_hit = (w_len_eff != '0) && (w_fill_next >= w_len_eff) &&
                 ((w_hist_next & w_mask) == (r_pattern & w_mask));

  assign w_cfg_ok  = cfg_we && (r_state == ST_IDLE) && !s_valid;
  assign w_cnt_inc = r_match && !(&r_cnt);
  assign w_irq_set = w_cnt_inc && (r_thresh != '0) && ((r_cnt + CNT_W'(1)) == r_thresh);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_word    <= '0;
      r_bitcnt  <= '0;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= PAT_MAX'(3'b101);
      r_len     <= 4'd3;
      r_thresh  <= '0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
      r_irq     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= 1'b0;
      r_cfg_err <= cfg_we && !w_cfg_ok;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_word   <= s_data;
            r_bitcnt <= c_BIT_W'(WORD_W - 1);
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_hist  <= w_hist_next;
          r_fill  <= w_fill_next;
          r_match <= w_hit;
          if (w_last) begin
            if (w_accept) begin
              r_word   <= s_data;
              r_bitcnt <= c_BIT_W'(WORD_W - 1);
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_word   <= {r_word[WORD_W-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - c_BIT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);

      if (w_irq_set)    r_irq <= 1'b1;
      else if (irq_clr) r_irq <= 1'b0;

      // A config write only lands in IDLE, so it never races a shift update.
      if (w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_thresh  <= cfg_thresh;
        r_hist    <= '0;
        r_fill    <= '0;
        r_cnt     <= '0;
        r_irq     <= 1'b0;
      end
    end
  end

  assign s_ready   = w_ready;
  assign busy      = (r_state == ST_SHIFT);
  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign irq       = r_irq;
  assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_seqdet_stream_ctrl.sv
// ============================================================================
// Module  : tb_seqdet_stream_ctrl
// Brief   : Scoreboard bench for seqdet_stream_ctrl (expected match cycles queued
//           at word accept, popped when match pulses).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seqdet_stream_ctrl;

  localparam int WORD_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [PAT_MAX-1:0] cfg_pattern = '0;
  logic [3:0]         cfg_len = '0;
  logic [CNT_W-1:0]   cfg_thresh = '0;
  logic               cfg_err;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WORD_W-1:0]  s_data = '0;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               irq;
  logic               irq_clr = 1'b0;

  seqdet_stream_ctrl #(.WORD_W(WORD_W), .PAT_MAX(PAT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_thresh(cfg_thresh), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .busy(busy), .match(match), .match_cnt(match_cnt),
    .irq(irq), .irq_clr(irq_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  int q_exp[$];
  logic [7:0] m_hist;
  int m_fill;
  logic [7:0] m_pat;
  int m_len;
  int m_cnt;
  int n_match_seen = 0;
  int first_match_cyc = 0;
  int last_k = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, act, exp);
  endtask

  task automatic model_defaults();
    m_pat  = 8'b101;
    m_len  = 3;
    m_hist = '0;
    m_fill = 0;
    m_cnt  = 0;
    q_exp.delete();
  endtask

  // Expected behaviour for one accepted word: bit i is consumed on edge k+1+i
  // and its match pulse is visible right after that edge.
  task automatic model_word(input logic [7:0] d, input int k);
    int eff;
    logic [7:0] mask;
    bit hit;
    for (int i = 0; i < 8; i++) begin
      m_hist = {m_hist[6:0], d[7-i]};
      if (m_fill < 8) m_fill++;
      eff  = (m_len > 8) ? 8 : m_len;
      mask = 8'((1 << eff) - 1);
      hit  = (eff != 0) && (m_fill >= eff) && ((m_hist & mask) == (m_pat & mask));
      if (hit) begin
        q_exp.push_back(k + 1 + i);
        if (m_cnt < 65535) m_cnt++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (match) begin
      if (q_exp.size() == 0) check("match_unexpected", cyc, -1);
      else check("match_cycle", cyc, q_exp.pop_front());
      if (n_match_seen == 0) first_match_cyc = cyc;
      n_match_seen++;
    end
  end

  task automatic send_word(input logic [7:0] d, input bit last);
    int t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      check("ready_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    last_k = cyc + 1;
    model_word(d, last_k);
    @(posedge clk);
    if (last) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = '0;
    end
  endtask

  task automatic wait_to(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    repeat (14) @(negedge clk);
    check({tag, "_missing"}, q_exp.size(), 0);
    check({tag, "_cnt"}, int'(match_cnt), m_cnt);
  endtask

  task automatic cfg_write(input logic [7:0] p, input int len, input int th, input bit exp_ok);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = 4'(len);
    cfg_thresh  = 16'(th);
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err", int'(cfg_err), exp_ok ? 0 : 1);
    if (exp_ok) begin
      m_pat = p; m_len = len; m_hist = '0; m_fill = 0; m_cnt = 0;
      check("cfg_cnt_clr", int'(match_cnt), 0);
    end
  endtask

  initial begin
    int k, k1, k2, seen0;

    model_defaults();
    repeat (3) @(negedge clk);
    check("rst_ready", int'(s_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_match", int'(match), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_irq", int'(irq), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", int'(s_ready), 1);

    // Default pattern 101 on 1010_1000.
    send_word(8'b1010_1000, 1'b1);
    k = last_k;
    wait_to(k + 7);
    check("busy_last_shift", int'(busy), 1);
    wait_to(k + 8);
    check("busy_done", int'(busy), 0);
    drain("t1");
    check("t1_nmatch", n_match_seen, 2);
    check("t1_first_lat", first_match_cyc - k, 3);
    check("t1_irq", int'(irq), 0);

    // Threshold 2 with set-wins-over-clear.
    cfg_write(8'b101, 3, 2, 1'b1);
    send_word(8'b1010_1000, 1'b1);
    k = last_k;
    wait_to(k + 5);
    check("irq_pre", int'(irq), 0);
    irq_clr = 1'b1;
    wait_to(k + 6);
    check("irq_set_wins", int'(irq), 1);
    wait_to(k + 7);
    check("irq_cleared", int'(irq), 0);
    irq_clr = 1'b0;
    drain("t2");

    // Config write during SHIFT is rejected.
    cfg_write(8'b101, 3, 0, 1'b1);
    send_word(8'b1010_1000, 1'b1);
    k = last_k;
    wait_to(k + 2);
    cfg_we = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd8; cfg_thresh = 16'd1;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_reject_err", int'(cfg_err), 1);
    @(negedge clk);
    check("cfg_err_pulse", int'(cfg_err), 0);
    drain("t3");
    check("t3_irq", int'(irq), 0);

    // Back-to-back words with a match straddling the boundary.
    cfg_write(8'b101, 3, 0, 1'b1);
    seen0 = n_match_seen;
    send_word(8'b0000_0010, 1'b0);
    k1 = last_k;
    send_word(8'b1000_0000, 1'b1);
    k2 = last_k;
    check("b2b_gap", k2 - k1, 8);
    check("b2b_busy", int'(busy), 1);
    drain("t4");
    check("t4_nmatch", n_match_seen - seen0, 1);

    // Full-width pattern, then len 0.
    cfg_write(8'hA5, 8, 0, 1'b1);
    seen0 = n_match_seen;
    send_word(8'hA5, 1'b1);
    drain("t5a");
    check("t5a_nmatch", n_match_seen - seen0, 1);
    cfg_write(8'hA5, 0, 0, 1'b1);
    seen0 = n_match_seen;
    send_word(8'hA5, 1'b1);
    drain("t5b");
    check("t5b_nmatch", n_match_seen - seen0, 0);

    // Reset mid-word, with a match about to complete on the reset edge.
    cfg_write(8'b0101, 4, 5, 1'b1);
    send_word(8'b0101_0000, 1'b1);
    k = last_k;
    wait_to(k + 3);
    rst = 1'b1;
    wait_to(k + 4);
    q_exp.delete();
    check("mid_rst_ready", int'(s_ready), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_match", int'(match), 0);
    check("mid_rst_cnt", int'(match_cnt), 0);
    model_defaults();
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", int'(s_ready), 1);

    // Defaults restored: 101 gives two matches on 1010_1000.
    seen0 = n_match_seen;
    send_word(8'b1010_1000, 1'b1);
    drain("t6");
    check("t6_nmatch", n_match_seen - seen0, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got cycle %0d want finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
